// File: rtl/branch_fb_if.sv
// rtl/branch_fb_if.sv - Fetch allocate, execute resolve and predictor feedback signals of branch_fb_gen
interface branch_fb_if #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 32
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                       ext_flush;
    logic [1:0]                 alloc_valid;
    logic [1:0][ADDR_WIDTH-1:0] alloc_pred_pc;
    logic                       alloc_ready;
    logic [1:0][TAG_W-1:0]      alloc_tag;
    logic [1:0]                 res_valid;
    logic [1:0][TAG_W-1:0]      res_tag;
    logic [1:0]                 res_is_branch;
    logic [1:0][ADDR_WIDTH-1:0] res_actual_pc;
    logic [1:0]                 fb_if_branch;
    logic [1:0]                 fb_pred_correct;
    logic [1:0][ADDR_WIDTH-1:0] fb_new_pc;
    logic [TAG_W:0]             occupancy;

    modport master (
        output ext_flush, alloc_valid, alloc_pred_pc,
        output res_valid, res_tag, res_is_branch, res_actual_pc,
        input  alloc_ready, alloc_tag, fb_if_branch, fb_pred_correct, fb_new_pc, occupancy
    );

    modport slave (
        input  ext_flush, alloc_valid, alloc_pred_pc,
        input  res_valid, res_tag, res_is_branch, res_actual_pc,
        output alloc_ready, alloc_tag, fb_if_branch, fb_pred_correct, fb_new_pc, occupancy
    );
endinterface

// File: rtl/branch_fb_gen.sv
// rtl/branch_fb_gen.sv - In-flight next-PC guesses checked against resolved PCs, registered 2-lane branch feedback
// Optional BRANCH_FB_STATS_EN adds saturating branch/mispredict counters.
module branch_fb_gen #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    branch_fb_if.slave  bus
`ifdef BRANCH_FB_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam int PW    = TAG_W + 1;

    typedef logic [TAG_W-1:0]      tag_t;
    typedef logic [PW-1:0]         ptr_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    ptr_t                       head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]           valid_q, valid_d, resolved_q, resolved_d;
    addr_t                      pred_q [DEPTH];
    addr_t                      pred_d [DEPTH];
    logic [1:0]                 fb_br_q, fb_br_d, fb_ok_q, fb_ok_d;
    logic [1:0][ADDR_WIDTH-1:0] fb_pc_q, fb_pc_d;

    ptr_t       occ;
    logic       alloc_ready;
    tag_t       head_tag, tail_tag;
    logic [1:0] live, miss;
    tag_t       age [2];
    logic [1:0] src;
    logic       suppress, flush_mp;
    tag_t       flush_age;

    function automatic tag_t age_of(tag_t t, tag_t h);
        return t - h;
    endfunction

    // src[0] is the resolve lane reported on fb lane 0 (the older one), src[1] on fb lane 1.
    always_comb begin
        occ         = tail_q - head_q;
        alloc_ready = (occ <= ptr_t'(DEPTH - 2));
        head_tag    = head_q[TAG_W-1:0];
        tail_tag    = tail_q[TAG_W-1:0];
        for (int i = 0; i < 2; i++) begin
            live[i] = bus.res_valid[i] & valid_q[bus.res_tag[i]];
            miss[i] = live[i] & bus.res_is_branch[i]
                      & (bus.res_actual_pc[i] != pred_q[bus.res_tag[i]]);
            age[i]  = age_of(bus.res_tag[i], head_tag);
        end
        src       = (live == 2'b11 && age[1] < age[0]) ? 2'b01 : 2'b10;
        suppress  = (live == 2'b11) & miss[src[0]];
        flush_mp  = miss[src[0]] | (miss[src[1]] & ~suppress);
        flush_age = miss[src[0]] ? age[src[0]] : age[src[1]];
    end

    assign bus.occupancy       = occ;
    assign bus.alloc_ready     = alloc_ready;
    assign bus.alloc_tag[0]    = tail_tag;
    assign bus.alloc_tag[1]    = tail_tag + tag_t'(bus.alloc_valid[0]);
    assign bus.fb_if_branch    = fb_br_q;
    assign bus.fb_pred_correct = fb_ok_q;
    assign bus.fb_new_pc       = fb_pc_q;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        valid_d    = valid_q;
        resolved_d = resolved_q;
        pred_d     = pred_q;
        fb_br_d    = '0;
        fb_ok_d    = '0;
        fb_pc_d    = '0;
        if (bus.ext_flush) begin
            valid_d = '0;
            tail_d  = head_q;
        end else begin
            // Retire sees only state from before this cycle's resolves.
            if (valid_q[head_tag] && resolved_q[head_tag]) begin
                valid_d[head_tag] = 1'b0;
                head_d            = head_q + ptr_t'(1);
                if (valid_q[head_tag + tag_t'(1)] && resolved_q[head_tag + tag_t'(1)]) begin
                    valid_d[head_tag + tag_t'(1)] = 1'b0;
                    head_d                        = head_q + ptr_t'(2);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (live[src[k]] && !(k == 1 && suppress)) begin
                    resolved_d[bus.res_tag[src[k]]] = 1'b1;
                    if (bus.res_is_branch[src[k]]) begin
                        fb_br_d[k] = 1'b1;
                        fb_ok_d[k] = ~miss[src[k]];
                        fb_pc_d[k] = bus.res_actual_pc[src[k]];
                    end
                end
            end
            if (flush_mp) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (age_of(tag_t'(j), head_tag) > flush_age) valid_d[j] = 1'b0;
                end
                tail_d = head_q + ptr_t'(flush_age) + ptr_t'(1);
            end else if (alloc_ready) begin
                if (bus.alloc_valid[0]) begin
                    valid_d[tail_tag]    = 1'b1;
                    resolved_d[tail_tag] = 1'b0;
                    pred_d[tail_tag]     = bus.alloc_pred_pc[0];
                end
                if (bus.alloc_valid[1]) begin
                    valid_d[bus.alloc_tag[1]]    = 1'b1;
                    resolved_d[bus.alloc_tag[1]] = 1'b0;
                    pred_d[bus.alloc_tag[1]]     = bus.alloc_pred_pc[1];
                end
                tail_d = tail_q + ptr_t'(bus.alloc_valid[0]) + ptr_t'(bus.alloc_valid[1]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= '0;
            resolved_q <= '0;
            for (int j = 0; j < DEPTH; j++) pred_q[j] <= '0;
            fb_br_q    <= '0;
            fb_ok_q    <= '0;
            fb_pc_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            pred_q     <= pred_d;
            fb_br_q    <= fb_br_d;
            fb_ok_q    <= fb_ok_d;
            fb_pc_q    <= fb_pc_d;
        end
    end

`ifdef BRANCH_FB_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;
    logic [1:0]  fb_mp_d;

    function automatic logic [31:0] sat_add(logic [31:0] a, logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        fb_mp_d   = fb_br_d & ~fb_ok_d;
        stat_br_d = sat_add(stat_br_q, {1'b0, fb_br_d[0]} + {1'b0, fb_br_d[1]});
        stat_mp_d = sat_add(stat_mp_q, {1'b0, fb_mp_d[0]} + {1'b0, fb_mp_d[1]});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif
endmodule

// File: tb/tb_branch_fb_gen.sv
// tb/tb_branch_fb_gen.sv - Directed and randomized checks of branch_fb_gen against a queue-level reference model
module tb_branch_fb_gen;
    localparam int D  = 16;
    localparam int AW = 32;
    localparam int TW = $clog2(D);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_fb_if #(.DEPTH(D), .ADDR_WIDTH(AW)) bfi ();
`ifdef BRANCH_FB_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_fb_gen #(.DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bfi.slave)
`ifdef BRANCH_FB_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: absolute sequence numbers, slot = seq mod D.
    int            m_head, m_tail;
    bit            m_valid [D];
    bit            m_res   [D];
    logic [AW-1:0] m_pred  [D];
    bit            e_br [2];
    bit            e_ok [2];
    logic [AW-1:0] e_pc [2];
    longint        e_sb, e_sm;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int age(int tag);
        return ((tag - m_head) % D + D) % D;
    endfunction

    task automatic model_reset();
        m_head = 0;
        m_tail = 0;
        for (int j = 0; j < D; j++) begin
            m_valid[j] = 0;
            m_res[j]   = 0;
            m_pred[j]  = '0;
        end
        for (int k = 0; k < 2; k++) begin
            e_br[k] = 0;
            e_ok[k] = 0;
            e_pc[k] = '0;
        end
        e_sb = 0;
        e_sm = 0;
    endtask

    task automatic model_step();
        bit            nv [D];
        bit            nr [D];
        logic [AW-1:0] np [D];
        int            nt, occ, n, nlive, t_age, s, ln, tg, slot;
        int            ord [2];
        bit            flushed;
        logic [AW-1:0] act;
        nv = m_valid; nr = m_res; np = m_pred;
        nt = m_tail;
        occ = m_tail - m_head;
        n = 0;
        for (int k = 0; k < 2; k++) begin
            e_br[k] = 0; e_ok[k] = 0; e_pc[k] = '0;
        end
        if (bfi.ext_flush) begin
            for (int j = 0; j < D; j++) nv[j] = 0;
            nt = m_head;
        end else begin
            while (n < 2 && m_valid[(m_head + n) % D] && m_res[(m_head + n) % D]) begin
                nv[(m_head + n) % D] = 0;
                n++;
            end
            nlive = 0;
            ord[0] = 0; ord[1] = 1;
            for (int i = 0; i < 2; i++)
                if (bfi.res_valid[i] && m_valid[bfi.res_tag[i]]) begin
                    ord[nlive] = i;
                    nlive++;
                end
            if (nlive == 2 && age(int'(bfi.res_tag[1])) < age(int'(bfi.res_tag[0]))) begin
                ord[0] = 1; ord[1] = 0;
            end
            flushed = 0;
            t_age   = 0;
            for (int k = 0; k < nlive; k++) begin
                ln = ord[k];
                tg = int'(bfi.res_tag[ln]);
                if (!flushed) begin
                    nr[tg] = 1;
                    slot = (nlive == 2) ? k : ln;
                    act  = bfi.res_actual_pc[ln];
                    if (bfi.res_is_branch[ln]) begin
                        e_br[slot] = 1;
                        e_pc[slot] = act;
                        e_ok[slot] = (act == m_pred[tg]);
                        if (!e_ok[slot]) begin
                            flushed = 1;
                            t_age   = age(tg);
                        end
                    end
                end
            end
            if (flushed) begin
                for (int j = 0; j < D; j++) if (age(j) > t_age) nv[j] = 0;
                nt = m_head + t_age + 1;
            end else if (occ <= D - 2) begin
                s = m_tail;
                for (int i = 0; i < 2; i++)
                    if (bfi.alloc_valid[i]) begin
                        nv[s % D] = 1;
                        nr[s % D] = 0;
                        np[s % D] = bfi.alloc_pred_pc[i];
                        s++;
                    end
                nt = s;
            end
        end
        for (int k = 0; k < 2; k++) begin
            e_sb += longint'(e_br[k]);
            e_sm += longint'(e_br[k] && !e_ok[k]);
        end
        m_valid = nv; m_res = nr; m_pred = np;
        m_head  = m_head + n;
        m_tail  = nt;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("occupancy", 64'(bfi.occupancy), 64'(m_tail - m_head));
            chk("alloc_ready", 64'(bfi.alloc_ready), 64'((m_tail - m_head) <= D - 2));
            chk("alloc_tag0", 64'(bfi.alloc_tag[0]), 64'(m_tail % D));
            chk("alloc_tag1", 64'(bfi.alloc_tag[1]), 64'((m_tail + int'(bfi.alloc_valid[0])) % D));
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("fb_if_branch%0d", k), 64'(bfi.fb_if_branch[k]), 64'(e_br[k]));
                chk($sformatf("fb_pred_correct%0d", k), 64'(bfi.fb_pred_correct[k]), 64'(e_ok[k]));
                chk($sformatf("fb_new_pc%0d", k), 64'(bfi.fb_new_pc[k]), 64'(e_pc[k]));
            end
`ifdef BRANCH_FB_STATS_EN
            chk("stat_branches", 64'(stat_branches), 64'(e_sb));
            chk("stat_mispredicts", 64'(stat_mispredicts), 64'(e_sm));
`endif
        end
    end

    task automatic idle();
        bfi.ext_flush     = 1'b0;
        bfi.alloc_valid   = '0;
        bfi.alloc_pred_pc = '0;
        bfi.res_valid     = '0;
        bfi.res_tag       = '0;
        bfi.res_is_branch = '0;
        bfi.res_actual_pc = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc2(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        bfi.alloc_valid      = 2'b11;
        bfi.alloc_pred_pc[0] = p0;
        bfi.alloc_pred_pc[1] = p1;
        tick();
        idle();
    endtask

    task automatic set_res(input int lane, input int tag, input bit br, input logic [AW-1:0] pc);
        bfi.res_valid[lane]     = 1'b1;
        bfi.res_tag[lane]       = TW'(tag);
        bfi.res_is_branch[lane] = br;
        bfi.res_actual_pc[lane] = pc;
    endtask

    function automatic logic [AW-1:0] pp(int t);
        return AW'(32'h100 + t * 4);
    endfunction

    task automatic check_fb_zero(input string pfx);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_fb_br%0d", pfx, k), 64'(bfi.fb_if_branch[k]), 64'd0);
            chk($sformatf("%s_fb_ok%0d", pfx, k), 64'(bfi.fb_pred_correct[k]), 64'd0);
            chk($sformatf("%s_fb_pc%0d", pfx, k), 64'(bfi.fb_new_pc[k]), 64'd0);
        end
    endtask

    task automatic rand_inputs();
        int cand [$];
        int p, t;
        idle();
        bfi.ext_flush   = ($urandom_range(0, 39) == 0);
        bfi.alloc_valid = 2'($urandom_range(0, 3));
        for (int i = 0; i < 2; i++) bfi.alloc_pred_pc[i] = AW'($urandom_range(0, 15)) << 4;
        for (int j = 0; j < D; j++) if (m_valid[j] && !m_res[j]) cand.push_back(j);
        for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                t = -1;
                if (cand.size() > 0 && $urandom_range(0, 7) != 0) begin
                    p = $urandom_range(0, cand.size() - 1);
                    t = cand[p];
                    cand.delete(p);
                end else begin
                    p = $urandom_range(0, D - 1);
                    if (!m_valid[p]) t = p;
                end
                if (t >= 0)
                    set_res(i, t, $urandom_range(0, 3) != 0,
                            ($urandom_range(0, 3) == 0) ? AW'($urandom) : m_pred[t]);
            end
        end
    endtask

    int guard;

    initial begin
        idle();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_occupancy", 64'(bfi.occupancy), 64'd0);
        chk("rst_alloc_ready", 64'(bfi.alloc_ready), 64'd1);
        check_fb_zero("rst");

        // Fill: two per cycle until full
        for (int c = 0; c < 8; c++) begin
            bfi.alloc_valid = 2'b11;
            #1;
            chk($sformatf("t1_tag0_c%0d", c), 64'(bfi.alloc_tag[0]), 64'(2 * c));
            chk($sformatf("t1_tag1_c%0d", c), 64'(bfi.alloc_tag[1]), 64'(2 * c + 1));
            alloc2(pp(2 * c), pp(2 * c + 1));
            if (c == 6) begin
                chk("t1_occ14", 64'(bfi.occupancy), 64'd14);
                chk("t1_ready14", 64'(bfi.alloc_ready), 64'd1);
            end
        end
        chk("t1_occ16", 64'(bfi.occupancy), 64'd16);
        chk("t1_ready16", 64'(bfi.alloc_ready), 64'd0);

        // Correct prediction, then mispredict at tag2 flushes 3..5
        do_reset();
        alloc2(pp(0), pp(1));
        alloc2(32'h10, 32'h40);
        alloc2(pp(4), pp(5));
        set_res(0, 3, 1, 32'h40);
        tick();
        idle();
        chk("t2_br", 64'(bfi.fb_if_branch[0]), 64'd1);
        chk("t2_ok", 64'(bfi.fb_pred_correct[0]), 64'd1);
        chk("t2_pc", 64'(bfi.fb_new_pc[0]), 64'h40);
        chk("t2_occ", 64'(bfi.occupancy), 64'd6);
        set_res(0, 2, 1, 32'h100);
        tick();
        idle();
        chk("t3_br", 64'(bfi.fb_if_branch[0]), 64'd1);
        chk("t3_ok", 64'(bfi.fb_pred_correct[0]), 64'd0);
        chk("t3_pc", 64'(bfi.fb_new_pc[0]), 64'h100);
        chk("t3_occ", 64'(bfi.occupancy), 64'd3);
        chk("t3_tail", 64'(bfi.alloc_tag[0]), 64'd3);
        set_res(0, 4, 1, 32'h55);
        tick();
        idle();
        chk("t3_stale_br", 64'(bfi.fb_if_branch[0]), 64'd0);
        chk("t3_stale_occ", 64'(bfi.occupancy), 64'd3);

        // Younger-on-lane0 correct, older-on-lane1 mispredict
        do_reset();
        alloc2(pp(0), pp(1));
        alloc2(pp(2), pp(3));
        alloc2(pp(4), pp(5));
        set_res(0, 5, 1, pp(5));
        set_res(1, 1, 1, 32'h777);
        tick();
        idle();
        chk("t4_fb0_br", 64'(bfi.fb_if_branch[0]), 64'd1);
        chk("t4_fb0_ok", 64'(bfi.fb_pred_correct[0]), 64'd0);
        chk("t4_fb0_pc", 64'(bfi.fb_new_pc[0]), 64'h777);
        chk("t4_fb1_br", 64'(bfi.fb_if_branch[1]), 64'd0);
        chk("t4_occ", 64'(bfi.occupancy), 64'd2);

        // Wrap: drain to head=14, allocate 14..1, mispredict 15
        do_reset();
        for (int c = 0; c < 7; c++) alloc2(pp(2 * c), pp(2 * c + 1));
        for (int c = 0; c < 7; c++) begin
            set_res(0, 2 * c, 0, 32'h0);
            set_res(1, 2 * c + 1, 0, 32'h0);
            tick();
            idle();
        end
        guard = 0;
        while (bfi.occupancy != 0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("t5_drain", 64'(bfi.occupancy), 64'd0);
        chk("t5_head14", 64'(bfi.alloc_tag[0]), 64'd14);
        alloc2(32'h200, 32'h204);
        alloc2(32'h208, 32'h20c);
        chk("t5_occ4", 64'(bfi.occupancy), 64'd4);
        chk("t5_tail2", 64'(bfi.alloc_tag[0]), 64'd2);
        set_res(0, 15, 1, 32'h999);
        tick();
        idle();
        chk("t5_occ2", 64'(bfi.occupancy), 64'd2);
        chk("t5_tail0", 64'(bfi.alloc_tag[0]), 64'd0);
        chk("t5_fb_ok", 64'(bfi.fb_pred_correct[0]), 64'd0);
        set_res(0, 14, 0, 32'h0);
        tick();
        idle();
        tick();
        tick();
        chk("t5_retired", 64'(bfi.occupancy), 64'd0);
        chk("t5_head0", 64'(bfi.alloc_tag[0]), 64'd0);

        // ext_flush beats a same-cycle allocation and mispredict
        do_reset();
        alloc2(32'h300, 32'h304);
        alloc2(32'h308, 32'h30c);
        set_res(0, 0, 1, 32'h300);
        tick();
        idle();
`ifdef BRANCH_FB_STATS_EN
        chk("t6_stat_br_pre", 64'(stat_branches), 64'd1);
`endif
        bfi.ext_flush   = 1'b1;
        bfi.alloc_valid = 2'b11;
        set_res(0, 1, 1, 32'hbad);
        tick();
        idle();
        chk("t6_occ", 64'(bfi.occupancy), 64'd0);
        check_fb_zero("t6");
`ifdef BRANCH_FB_STATS_EN
        chk("t6_stat_br", 64'(stat_branches), 64'd1);
        chk("t6_stat_mp", 64'(stat_mispredicts), 64'd0);
`endif

        // Randomized traffic with an asynchronous reset in the middle
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rand_inputs();
            tick();
            if (c == 750) begin
                #1 reset = 1'b1;
                #1;
                chk("arst_occ", 64'(bfi.occupancy), 64'd0);
                chk("arst_ready", 64'(bfi.alloc_ready), 64'd1);
                check_fb_zero("arst");
`ifdef BRANCH_FB_STATS_EN
                chk("arst_stat", 64'(stat_branches), 64'd0);
`endif
                idle();
                @(posedge clk);
                #2 reset = 1'b0;
            end
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
